shift_word_assembler: RTL and testbench

- Downstream consumer of the bidirectional shift register's serial output bit.
- Collects serial bits into WIDTH-bit parallel words, honouring the register's shift direction so the bit order is restored.
- Hands completed words to the next stage through a 2-entry output buffer with a valid/ready handshake.
- Flags overflow when the buffer cannot accept a completed word.

---
 rtl/shift_word_assembler_pkg.sv | 17 +
 rtl/shift_word_assembler_fifo.sv | 86 ++++++++
 rtl/shift_word_assembler.sv | 115 +++++++++++
 tb/tb_shift_word_assembler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_word_assembler_pkg.sv
// Shared constants and buffer tag type for shift_word_assembler.
// Optional macro SHIFT_ASM_PARITY_EN adds a parity bit to each buffered tag.
package shift_asm_pkg;

  localparam logic DIR_RIGHT     = 1'b0;
  localparam logic DIR_LEFT      = 1'b1;
  localparam int   ASM_BUF_DEPTH = 2;

  // The word payload is sized by the assembler's WIDTH, so it travels next to this tag.
  typedef struct packed {
    logic dir;
`ifdef SHIFT_ASM_PARITY_EN
    logic parity;
`endif
  } asm_tag_t;

endpackage

// File: rtl/shift_word_assembler_fifo.sv
// Two-entry output buffer with a registered head; accepts a push while full if a pop happens in the same cycle.
// Tag width follows SHIFT_ASM_PARITY_EN through asm_tag_t.
module shift_asm_fifo
  import shift_asm_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  asm_tag_t          push_tag,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data,
  output asm_tag_t          head_tag
);

  logic [DATA_W-1:0] head_data_r, tail_data_r, head_data_next_s, tail_data_next_s;
  asm_tag_t          head_tag_r, tail_tag_r, head_tag_next_s, tail_tag_next_s;
  logic [1:0]        count_r, count_next_s;
  logic              push_ok_s, pop_ok_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign head_data = head_data_r;
  assign head_tag  = head_tag_r;

  // Next-state for head/tail slots: the head always holds the oldest entry.
  always_comb begin
    head_data_next_s = head_data_r;
    head_tag_next_s  = head_tag_r;
    tail_data_next_s = tail_data_r;
    tail_tag_next_s  = tail_tag_r;
    pop_ok_s  = pop && (count_r != 2'd0);
    push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    case (count_r)
      2'd0: begin
        head_data_next_s = push_ok_s ? push_data : head_data_r;
        head_tag_next_s  = push_ok_s ? push_tag  : head_tag_r;
      end
      2'd1: begin
        if (pop_ok_s) begin
          head_data_next_s = push_ok_s ? push_data : head_data_r;
          head_tag_next_s  = push_ok_s ? push_tag  : head_tag_r;
        end else begin
          tail_data_next_s = push_ok_s ? push_data : tail_data_r;
          tail_tag_next_s  = push_ok_s ? push_tag  : tail_tag_r;
        end
      end
      2'd2: begin
        if (pop_ok_s) begin
          head_data_next_s = tail_data_r;
          head_tag_next_s  = tail_tag_r;
          tail_data_next_s = push_ok_s ? push_data : tail_data_r;
          tail_tag_next_s  = push_ok_s ? push_tag  : tail_tag_r;
        end else begin
          tail_data_next_s = tail_data_r;
        end
      end
      default: begin
        head_data_next_s = head_data_r;
      end
    endcase
    count_next_s = count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_data_r <= {DATA_W{1'b0}};
      tail_data_r <= {DATA_W{1'b0}};
      head_tag_r  <= '{default: 1'b0};
      tail_tag_r  <= '{default: 1'b0};
      count_r     <= 2'd0;
    end else begin
      head_data_r <= head_data_next_s;
      tail_data_r <= tail_data_next_s;
      head_tag_r  <= head_tag_next_s;
      tail_tag_r  <= tail_tag_next_s;
      count_r     <= count_next_s;
    end
  end

endmodule

// File: rtl/shift_word_assembler.sv
// Reassembles serial bits from the bidirectional shift register into WIDTH-bit words.
// Optional macro SHIFT_ASM_PARITY_EN adds the out_parity port.
module shift_word_assembler
  import shift_asm_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BUF_DEPTH = ASM_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  input  logic                     shift_dir,
  input  logic                     frame_start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_dir,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overflow
`ifdef SHIFT_ASM_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("shift_word_assembler: WIDTH must be >= 2");
  end
  if (BUF_DEPTH != ASM_BUF_DEPTH) begin : g_bad_depth
    $error("shift_word_assembler: BUF_DEPTH is fixed at 2");
  end

`ifdef SHIFT_ASM_PARITY_EN
  function automatic logic word_parity(input logic [WIDTH-1:0] word);
    word_parity = ^word;
  endfunction
`endif

  logic [CNT_W-1:0] bit_cnt_r, cnt_base_s, cnt_next_s, pos_s;
  logic [WIDTH-1:0] word_r, word_base_s, word_fill_s, word_next_s;
  logic             dir_r, dir_cur_s, dir_next_s;
  logic             overflow_r, overflow_next_s;
  logic             complete_s, pop_s, fifo_full_s, fifo_empty_s;
  asm_tag_t         push_tag_s, head_tag_s;

  // Bit placement: frame_start restarts the word, direction is latched on bit 0.
  always_comb begin
    cnt_base_s  = frame_start ? {CNT_W{1'b0}} : bit_cnt_r;
    word_base_s = frame_start ? {WIDTH{1'b0}} : word_r;
    dir_cur_s   = (cnt_base_s == {CNT_W{1'b0}}) ? shift_dir : dir_r;
    pos_s       = (dir_cur_s == DIR_LEFT) ? (LAST_IDX - cnt_base_s) : cnt_base_s;
    word_fill_s = word_base_s;
    word_fill_s[pos_s] = bit_in;
    complete_s  = bit_valid && (cnt_base_s == LAST_IDX);
    if (bit_valid) begin
      cnt_next_s  = complete_s ? {CNT_W{1'b0}} : (cnt_base_s + CNT_W'(1));
      word_next_s = complete_s ? {WIDTH{1'b0}} : word_fill_s;
      dir_next_s  = dir_cur_s;
    end else begin
      cnt_next_s  = cnt_base_s;
      word_next_s = word_base_s;
      dir_next_s  = dir_r;
    end
    push_tag_s     = '{default: 1'b0};
    push_tag_s.dir = dir_cur_s;
`ifdef SHIFT_ASM_PARITY_EN
    push_tag_s.parity = word_parity(word_fill_s);
`endif
    pop_s           = !fifo_empty_s && out_ready;
    overflow_next_s = overflow_r | (complete_s && fifo_full_s && !pop_s);
  end

  // Partial-word state and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r  <= {CNT_W{1'b0}};
      word_r     <= {WIDTH{1'b0}};
      dir_r      <= DIR_RIGHT;
      overflow_r <= 1'b0;
    end else begin
      bit_cnt_r  <= cnt_next_s;
      word_r     <= word_next_s;
      dir_r      <= dir_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  shift_asm_fifo #(
    .DATA_W (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (complete_s),
    .push_data (word_fill_s),
    .push_tag  (push_tag_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_data (out_data),
    .head_tag  (head_tag_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_dir   = head_tag_s.dir;
  assign bit_count = bit_cnt_r;
  assign overflow  = overflow_r;
`ifdef SHIFT_ASM_PARITY_EN
  assign out_parity = head_tag_s.parity;
`endif

endmodule

// File: tb/tb_shift_word_assembler.sv
// Self-checking bench for shift_word_assembler: directed vector table, async reset sequence, random vs reference model.
module tb_shift_word_assembler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         bit_valid = 1'b0, bit_in = 1'b0, shift_dir = 1'b0, frame_start = 1'b0, out_ready = 1'b0;
  logic         out_valid, out_dir, overflow;
  logic [W-1:0] out_data;
  logic [1:0]   bit_count;
`ifdef SHIFT_ASM_PARITY_EN
  logic         out_parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  shift_word_assembler #(.WIDTH(W), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .shift_dir   (shift_dir),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_dir     (out_dir),
    .bit_count   (bit_count),
    .overflow    (overflow)
`ifdef SHIFT_ASM_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, bv, bi, sd, fs, rdy;
    logic       ev;
    logic [3:0] ed;
    logic       edir;
    logic [1:0] ecnt;
    logic       eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic rst, bv, bi, sd, fs, rdy,
                            input logic ev, input logic [3:0] ed, input logic edir,
                            input logic [1:0] ecnt, input logic eovf);
    vec_t t;
    t.rst = rst; t.bv = bv; t.bi = bi; t.sd = sd; t.fs = fs; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.edir = edir; t.ecnt = ecnt; t.eovf = eovf;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic ev, input logic [3:0] ed,
                         input logic edir, input logic [1:0] ecnt, input logic eovf);
    n_vec++;
    chk({nm, ".out_valid"}, idx, {3'b000, out_valid}, {3'b000, ev});
    chk({nm, ".out_data"},  idx, out_data, ed);
    chk({nm, ".out_dir"},   idx, {3'b000, out_dir}, {3'b000, edir});
    chk({nm, ".bit_count"}, idx, {2'b00, bit_count}, {2'b00, ecnt});
    chk({nm, ".overflow"},  idx, {3'b000, overflow}, {3'b000, eovf});
`ifdef SHIFT_ASM_PARITY_EN
    chk({nm, ".out_parity"}, idx, {3'b000, out_parity}, {3'b000, ^ed});
`endif
  endtask

  task automatic step(input logic bv, bi, sd, fs, rdy);
    bit_valid = bv; bit_in = bi; shift_dir = sd; frame_start = fs; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    bit_valid = 1'b0; bit_in = 1'b0; shift_dir = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  // Reference model: word built from the list of received bits and the direction of bit 0.
  typedef struct { logic [3:0] d; logic dir; } ent_t;
  ent_t       mq[$];
  logic       mbits[$];
  logic       mdir, movf, mlast_dir;
  logic [3:0] mlast_d;

  task automatic model_reset();
    mq.delete(); mbits.delete();
    mdir = 1'b0; movf = 1'b0; mlast_d = 4'h0; mlast_dir = 1'b0;
  endtask

  task automatic model_step(input logic bv, bi, sd, fs, rdy);
    ent_t e;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (fs) mbits.delete();
    if (bv) begin
      if (mbits.size() == 0) mdir = sd;
      mbits.push_back(bi);
      if (mbits.size() == W) begin
        e.d = 4'h0;
        e.dir = mdir;
        for (int k = 0; k < W; k++) begin
          if (mdir) e.d[W-1-k] = mbits[k];
          else      e.d[k]     = mbits[k];
        end
        if (mq.size() < 2) mq.push_back(e);
        else               movf = 1'b1;
        mbits.delete();
      end
    end
    if (mq.size() > 0) begin
      mlast_d   = mq[0].d;
      mlast_dir = mq[0].dir;
    end
  endtask

  initial begin
    logic bv, bi, sd, fs, rdy;
    logic [3:0] w9;

    //  rst bv bi sd fs rdy | ev ed    dir cnt   ovf
    v(1, 0, 0, 0, 0, 0,  0, 4'h0, 0, 2'd0, 0);
    // LSB-first 0,1,0,1; ready on the completing bit must not bypass
    v(0, 1, 0, 0, 0, 0,  0, 4'h0, 0, 2'd1, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'h0, 0, 2'd2, 0);
    v(0, 1, 0, 0, 0, 0,  0, 4'h0, 0, 2'd3, 0);
    v(0, 1, 1, 0, 0, 1,  1, 4'hA, 0, 2'd0, 0);
    v(0, 0, 0, 0, 0, 0,  1, 4'hA, 0, 2'd0, 0);
    v(0, 0, 0, 0, 0, 1,  0, 4'hA, 0, 2'd0, 0);
    // MSB-first 1,0,1,0 with shift_dir dropping after bit 0
    v(0, 1, 1, 1, 0, 0,  0, 4'hA, 0, 2'd1, 0);
    v(0, 1, 0, 0, 0, 0,  0, 4'hA, 0, 2'd2, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'hA, 0, 2'd3, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'hA, 1, 2'd0, 0);
    v(0, 0, 0, 0, 0, 1,  0, 4'hA, 1, 2'd0, 0);
    // backpressure: 3, 5 buffered, 9 dropped
    v(0, 1, 1, 0, 0, 0,  0, 4'hA, 1, 2'd1, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'hA, 1, 2'd2, 0);
    v(0, 1, 0, 0, 0, 0,  0, 4'hA, 1, 2'd3, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd0, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'h3, 0, 2'd1, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd2, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'h3, 0, 2'd3, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd0, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'h3, 0, 2'd1, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd2, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd3, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'h3, 0, 2'd0, 1);
    v(0, 0, 0, 0, 0, 1,  1, 4'h5, 0, 2'd0, 1);
    v(0, 0, 0, 0, 0, 1,  0, 4'h5, 0, 2'd0, 1);
    v(0, 0, 0, 0, 0, 0,  0, 4'h5, 0, 2'd0, 1);
    // full buffer with completion and pop on the same edge
    v(1, 0, 0, 0, 0, 0,  0, 4'h0, 0, 2'd0, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'h0, 0, 2'd1, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'h0, 0, 2'd2, 0);
    v(0, 1, 0, 0, 0, 0,  0, 4'h0, 0, 2'd3, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd0, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'h3, 0, 2'd1, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd2, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'h3, 0, 2'd3, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd0, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd1, 0);
    v(0, 1, 0, 0, 0, 0,  1, 4'h3, 0, 2'd2, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'h3, 0, 2'd3, 0);
    v(0, 1, 1, 0, 0, 1,  1, 4'h5, 0, 2'd0, 0);
    v(0, 0, 0, 0, 0, 1,  1, 4'hC, 0, 2'd0, 0);
    v(0, 0, 0, 0, 0, 1,  0, 4'hC, 0, 2'd0, 0);
    // frame_start with a bit restarts the word at bit 0
    v(0, 1, 1, 0, 0, 0,  0, 4'hC, 0, 2'd1, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'hC, 0, 2'd2, 0);
    v(0, 1, 0, 0, 1, 0,  0, 4'hC, 0, 2'd1, 0);
    v(0, 1, 0, 0, 0, 0,  0, 4'hC, 0, 2'd2, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'hC, 0, 2'd3, 0);
    v(0, 1, 1, 0, 0, 0,  1, 4'hC, 0, 2'd0, 0);
    v(0, 0, 0, 0, 0, 1,  0, 4'hC, 0, 2'd0, 0);
    // frame_start alone clears count; direction re-latched on next bit
    v(0, 1, 1, 1, 0, 0,  0, 4'hC, 0, 2'd1, 0);
    v(0, 0, 0, 0, 1, 0,  0, 4'hC, 0, 2'd0, 0);
    v(0, 1, 1, 0, 0, 0,  0, 4'hC, 0, 2'd1, 0);
    v(0, 1, 0, 1, 0, 0,  0, 4'hC, 0, 2'd2, 0);
    v(0, 1, 0, 1, 0, 0,  0, 4'hC, 0, 2'd3, 0);
    v(0, 1, 0, 1, 0, 0,  1, 4'h1, 0, 2'd0, 0);

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) pulse_reset();
      else step(vecs[i].bv, vecs[i].bi, vecs[i].sd, vecs[i].fs, vecs[i].rdy);
      chk_all("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].edir, vecs[i].ecnt, vecs[i].eovf);
    end

    // Asynchronous reset mid-word with a full buffer and overflow set
    pulse_reset();
    w9 = 4'b1001;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < W; k++) step(1'b1, w9[W-1-k], 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("pre_rst", 0, 1'b1, 4'h9, 1'b1, 2'd3, 1'b1);
    bit_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("post_rst", 0, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0);

    // Randomized traffic against the reference model
    pulse_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bv  = ($urandom_range(0, 3) != 0);
      bi  = $urandom_range(0, 1);
      sd  = $urandom_range(0, 1);
      fs  = ($urandom_range(0, 15) == 0);
      rdy = ((i / 250) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
      model_step(bv, bi, sd, fs, rdy);
      step(bv, bi, sd, fs, rdy);
      chk_all("rand", i, (mq.size() > 0), mlast_d, mlast_dir, 2'(mbits.size()), movf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
